decode_pipe: RTL and testbench

- Parametrised, pipelined successor of the decode stage.
- Contains a register file with configurable width and depth, write-through bypass, and optional hardwired-zero register 0.
- Provides a 4-mode immediate extender, a jump-address former, load-use hazard detection, and a registered ID/EX output stage with stall and flush.
- Sits between fetch and execute; all outputs except HAZARD are registered.

---
 rtl/decode_pipe.sv | 141 ++++++++++++++
 tb/tb_decode_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: pipelined decode stage.
// Register file with write-through bypass and optional hardwired-zero r0,
// 4-mode immediate extender, jump-address former, load-use hazard detection
// and a registered ID/EX stage with stall and flush. Only HAZARD is
// combinational; every other output comes straight from a flop.
//
// Pipeline-control contract for the ID/EX stage (one place, read it once):
//   EN=1 advances the stage, EN=0 holds it. FLUSH or HAZARD replaces the
//   captured instruction with a bubble (valid_q=0, data 0). While HAZARD is
//   high the upstream stage must keep its inputs stable so the same
//   instruction is presented again once the load has left EX.
module decode_pipe #(
  parameter int ANCHO   = 32,
  parameter int NREG    = 32,
  parameter int DIR_W   = 5,
  parameter int ZERO_R0 = 1
) (
  input  logic               reloj,
  input  logic               reset_n,
  input  logic [DIR_W-1:0]   DIR_A,
  input  logic [DIR_W-1:0]   DIR_B,
  input  logic [DIR_W-1:0]   DIR_WRA,
  input  logic [ANCHO-1:0]   DI,
  input  logic               REG_WR,
  input  logic               REG_RD,
  input  logic [1:0]         SEL_I,
  input  logic [15:0]        IMD,
  input  logic [ANCHO-29:0]  PC_4,
  input  logic [25:0]        address,
  input  logic               EN,
  input  logic               FLUSH,
  input  logic               EX_LOAD,
  input  logic [DIR_W-1:0]   EX_DEST,
  output logic [ANCHO-1:0]   DOA,
  output logic [ANCHO-1:0]   DOB,
  output logic [ANCHO-1:0]   out_mux_sz,
  output logic [ANCHO-1:0]   out_addr,
  output logic               valid_q,
  output logic               HAZARD
);

  // Register count and zero-r0 flag in the widths the comparisons use.
  localparam logic [DIR_W:0] LP_NREG = (DIR_W+1)'(NREG);
  localparam logic           LP_Z    = (ZERO_R0 != 0);

  logic [ANCHO-1:0] r_regs [NREG];

  logic             w_wr_ok;
  logic             w_a_in;
  logic             w_b_in;
  logic [ANCHO-1:0] w_rd_a;
  logic [ANCHO-1:0] w_rd_b;
  logic [ANCHO-1:0] w_zext;
  logic [ANCHO-1:0] w_sext;
  logic [ANCHO-1:0] w_imm;
  logic [ANCHO-1:0] w_jmp;
  logic             w_hazard;

  logic [ANCHO-1:0] r_doa;
  logic [ANCHO-1:0] r_dob;
  logic [ANCHO-1:0] r_imm;
  logic [ANCHO-1:0] r_jmp;
  logic             r_valid;

  // A write lands only for an in-range address that is not a hardwired r0.
  assign w_wr_ok = !REG_WR && ({1'b0, DIR_WRA} < LP_NREG) && !(LP_Z && (DIR_WRA == '0));
  assign w_a_in  = ({1'b0, DIR_A} < LP_NREG);
  assign w_b_in  = ({1'b0, DIR_B} < LP_NREG);

  // Register file storage: reset clears everything and discards a same-cycle write.
  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[DIR_WRA] <= DI;
    end
  end

  // Read port A: disabled/r0 read 0, pending write bypasses, else array (0 if out of range).
  always_comb begin
    w_rd_a = '0;
    if (REG_RD)                                w_rd_a = '0;
    else if (LP_Z && (DIR_A == '0))            w_rd_a = '0;
    else if (w_wr_ok && (DIR_WRA == DIR_A))    w_rd_a = DI;
    else if (w_a_in)                           w_rd_a = r_regs[DIR_A];
  end

  // Read port B: same rules as port A.
  always_comb begin
    w_rd_b = '0;
    if (REG_RD)                                w_rd_b = '0;
    else if (LP_Z && (DIR_B == '0))            w_rd_b = '0;
    else if (w_wr_ok && (DIR_WRA == DIR_B))    w_rd_b = DI;
    else if (w_b_in)                           w_rd_b = r_regs[DIR_B];
  end

  assign w_zext = {{(ANCHO-16){1'b0}}, IMD};
  assign w_sext = {{(ANCHO-16){IMD[15]}}, IMD};

  // Immediate extender: zero, sign, upper-half (lui-style), branch offset.
  always_comb begin
    w_imm = '0;
    case (SEL_I)
      2'b00:   w_imm = w_zext;
      2'b01:   w_imm = w_sext;
      2'b10:   w_imm = w_zext << 16;
      default: w_imm = w_sext << 2;
    endcase
  end

  assign w_jmp = {PC_4, address, 2'b00};

  // Load-use hazard: a load in EX writes a register this instruction reads.
  assign w_hazard = EX_LOAD && ((EX_DEST == DIR_A) || (EX_DEST == DIR_B)) &&
                    !REG_RD && !(LP_Z && (EX_DEST == '0));
  assign HAZARD = w_hazard;

  // ID/EX stage: reset > flush > hazard bubble > hold > advance.
  always_ff @(posedge reloj) begin
    if (!reset_n || FLUSH || w_hazard) begin
      r_doa   <= '0;
      r_dob   <= '0;
      r_imm   <= '0;
      r_jmp   <= '0;
      r_valid <= 1'b0;
    end else if (EN) begin
      r_doa   <= w_rd_a;
      r_dob   <= w_rd_b;
      r_imm   <= w_imm;
      r_jmp   <= w_jmp;
      r_valid <= 1'b1;
    end
  end

  assign DOA        = r_doa;
  assign DOB        = r_dob;
  assign out_mux_sz = r_imm;
  assign out_addr   = r_jmp;
  assign valid_q    = r_valid;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: reset, bypass, r0, a vector table for the
// read/immediate/jump paths, then hand-written hazard/hold/flush/reset runs.
module tb_decode_pipe;

  logic        reloj;
  logic        reset_n;
  logic [4:0]  DIR_A, DIR_B, DIR_WRA, EX_DEST;
  logic [31:0] DI;
  logic        REG_WR, REG_RD, EN, FLUSH, EX_LOAD;
  logic [1:0]  SEL_I;
  logic [15:0] IMD;
  logic [3:0]  PC_4;
  logic [25:0] address;
  logic [31:0] DOA, DOB, out_mux_sz, out_addr;
  logic        valid_q, HAZARD;

  int n_total = 0;
  int n_pass  = 0;

  decode_pipe dut (
    .reloj(reloj), .reset_n(reset_n),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WRA(DIR_WRA), .DI(DI),
    .REG_WR(REG_WR), .REG_RD(REG_RD), .SEL_I(SEL_I), .IMD(IMD),
    .PC_4(PC_4), .address(address), .EN(EN), .FLUSH(FLUSH),
    .EX_LOAD(EX_LOAD), .EX_DEST(EX_DEST),
    .DOA(DOA), .DOB(DOB), .out_mux_sz(out_mux_sz), .out_addr(out_addr),
    .valid_q(valid_q), .HAZARD(HAZARD)
  );

  // Clock / reset
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic        rd_n;
    logic [1:0]  sel;
    logic [15:0] imd;
    logic [3:0]  pc4;
    logic [25:0] jaddr;
    logic [31:0] exp_doa;
    logic [31:0] exp_dob;
    logic [31:0] exp_imm;
    logic [31:0] exp_jmp;
  } vec_t;

  vec_t vecs [6];

  // Driver tasks
  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] v);
    REG_WR = 1'b0; DIR_WRA = a; DI = v; EN = 1'b0;
    step();
    REG_WR = 1'b1;
  endtask

  initial begin
    // Table: registers 1,2,5,31 preloaded below; 7 holds DEADBEEF from the bypass test.
    vecs[0] = '{5'd1,  5'd2,  1'b0, 2'b00, 16'h8001, 4'hA, 26'h3FFFFFF,
                32'h11111111, 32'h22222222, 32'h00008001, 32'hAFFFFFFC};
    vecs[1] = '{5'd5,  5'd31, 1'b0, 2'b01, 16'h8001, 4'h0, 26'h0000000,
                32'h55555555, 32'hCAFEF00D, 32'hFFFF8001, 32'h00000000};
    vecs[2] = '{5'd31, 5'd0,  1'b0, 2'b10, 16'h8001, 4'hF, 26'h0000001,
                32'hCAFEF00D, 32'h00000000, 32'h80010000, 32'hF0000004};
    vecs[3] = '{5'd7,  5'd1,  1'b0, 2'b11, 16'h8001, 4'h1, 26'h2AAAAAA,
                32'hDEADBEEF, 32'h11111111, 32'hFFFE0004, 32'h1AAAAAA8};
    vecs[4] = '{5'd2,  5'd5,  1'b0, 2'b11, 16'h7FFF, 4'h0, 26'h0000000,
                32'h22222222, 32'h55555555, 32'h0001FFFC, 32'h00000000};
    vecs[5] = '{5'd1,  5'd2,  1'b1, 2'b00, 16'hFFFF, 4'h3, 26'h0000010,
                32'h00000000, 32'h00000000, 32'h0000FFFF, 32'h30000040};

    // Reset with a same-cycle write to r3 that must be discarded.
    reset_n = 1'b0; REG_WR = 1'b0; DIR_WRA = 5'd3; DI = 32'hFFFFFFFF;
    REG_RD = 1'b1; DIR_A = 5'd0; DIR_B = 5'd0; SEL_I = 2'b00; IMD = 16'h0;
    PC_4 = 4'h0; address = 26'h0; EN = 1'b0; FLUSH = 1'b0;
    EX_LOAD = 1'b0; EX_DEST = 5'd0;
    step();
    check("rst_doa", DOA, 32'h0);
    check("rst_dob", DOB, 32'h0);
    check("rst_imm", out_mux_sz, 32'h0);
    check("rst_jmp", out_addr, 32'h0);
    check("rst_valid", {31'h0, valid_q}, 32'h0);
    reset_n = 1'b1; REG_WR = 1'b1; REG_RD = 1'b0; DIR_A = 5'd3; EN = 1'b1;
    step();
    check("rst_r3", DOA, 32'h0);
    check("rst_valid_adv", {31'h0, valid_q}, 32'h1);

    // Write-through bypass, then the stored value on the following cycle.
    REG_WR = 1'b0; DIR_WRA = 5'd7; DI = 32'hDEADBEEF; DIR_A = 5'd7;
    step();
    check("bypass", DOA, 32'hDEADBEEF);
    REG_WR = 1'b1; DI = 32'h0;
    step();
    check("stored", DOA, 32'hDEADBEEF);

    // Hardwired r0: write dropped, bypass suppressed.
    REG_WR = 1'b0; DIR_WRA = 5'd0; DI = 32'h1234; DIR_A = 5'd0;
    step();
    check("r0_bypass", DOA, 32'h0);
    REG_WR = 1'b1;
    step();
    check("r0_stored", DOA, 32'h0);

    write_reg(5'd1,  32'h11111111);
    write_reg(5'd2,  32'h22222222);
    write_reg(5'd5,  32'h55555555);
    write_reg(5'd31, 32'hCAFEF00D);

    // Table-driven read / immediate / jump vectors.
    for (int i = 0; i < 6; i++) begin
      DIR_A = vecs[i].a; DIR_B = vecs[i].b; REG_RD = vecs[i].rd_n;
      SEL_I = vecs[i].sel; IMD = vecs[i].imd; PC_4 = vecs[i].pc4;
      address = vecs[i].jaddr; EN = 1'b1; REG_WR = 1'b1;
      step();
      check($sformatf("v%0d_doa", i), DOA, vecs[i].exp_doa);
      check($sformatf("v%0d_dob", i), DOB, vecs[i].exp_dob);
      check($sformatf("v%0d_imm", i), out_mux_sz, vecs[i].exp_imm);
      check($sformatf("v%0d_jmp", i), out_addr, vecs[i].exp_jmp);
      check($sformatf("v%0d_valid", i), {31'h0, valid_q}, 32'h1);
    end

    // Load-use hazard on port B produces a bubble.
    REG_RD = 1'b0; DIR_A = 5'd1; DIR_B = 5'd5; EX_LOAD = 1'b1; EX_DEST = 5'd5; EN = 1'b1;
    #1;
    check("haz_on", {31'h0, HAZARD}, 32'h1);
    step();
    check("haz_valid", {31'h0, valid_q}, 32'h0);
    check("haz_dob", DOB, 32'h0);
    check("haz_doa", DOA, 32'h0);
    // Hazard is gated by read enable.
    REG_RD = 1'b1;
    #1;
    check("haz_rd_off", {31'h0, HAZARD}, 32'h0);
    // EX destination r0 never stalls.
    REG_RD = 1'b0; DIR_A = 5'd0; EX_DEST = 5'd0;
    #1;
    check("haz_r0", {31'h0, HAZARD}, 32'h0);
    EX_LOAD = 1'b0;

    // Hold for three cycles with EN=0 while inputs change.
    DIR_A = 5'd1; DIR_B = 5'd2; SEL_I = 2'b01; IMD = 16'h1234; PC_4 = 4'h2; address = 26'h5;
    EN = 1'b1;
    step();
    check("pre_hold_doa", DOA, 32'h11111111);
    EN = 1'b0; DIR_A = 5'd5; DIR_B = 5'd31; IMD = 16'hFFFF; PC_4 = 4'h9;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold%0d_doa", c), DOA, 32'h11111111);
      check($sformatf("hold%0d_dob", c), DOB, 32'h22222222);
      check($sformatf("hold%0d_imm", c), out_mux_sz, 32'h00001234);
      check($sformatf("hold%0d_jmp", c), out_addr, 32'h20000014);
      check($sformatf("hold%0d_valid", c), {31'h0, valid_q}, 32'h1);
    end

    // FLUSH overrides EN=0.
    FLUSH = 1'b1;
    step();
    check("flush_valid", {31'h0, valid_q}, 32'h0);
    check("flush_doa", DOA, 32'h0);
    check("flush_imm", out_mux_sz, 32'h0);
    FLUSH = 1'b0;

    // Reset during a flush with a pending write: all registers clear.
    EN = 1'b1; DIR_A = 5'd1;
    step();
    check("pre_rst_doa", DOA, 32'h11111111);
    reset_n = 1'b0; FLUSH = 1'b1; REG_WR = 1'b0; DIR_WRA = 5'd2; DI = 32'h77777777;
    step();
    reset_n = 1'b1; FLUSH = 1'b0; REG_WR = 1'b1; DIR_A = 5'd1; DIR_B = 5'd2;
    check("mid_rst_valid", {31'h0, valid_q}, 32'h0);
    step();
    check("post_rst_r1", DOA, 32'h0);
    check("post_rst_r2", DOB, 32'h0);
    check("post_rst_valid", {31'h0, valid_q}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
